// File: rtl/trb_mem_arbiter_pkg.sv
// Shared constants and types for the trace buffer memory arbiter.
// Holds buffer geometry, write burst limit and arbiter state enum.
package dtb_pkg;

  localparam int TRB_ADDR_WIDTH = 8;
  localparam int TRB_WIDTH = 32;

  // Longest run of back-to-back write slots
  // before a read slot is forced (adaptive mode).
  localparam int TRB_ARB_MAX_WBURST = 3;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_t;

endpackage

// File: rtl/trb_mem_arbiter_if.sv
// Logger/memory-side bundle of the trace buffer arbiter.
// slave: arbiter side; master: logger + RAM side.
// Ports: CLEAR_I, WRITE_I, WRITE_PTR_I, READ_PTR_I, DATA_I,
//   MEM_RDATA_I in; RW_TURN_O, WRITE_ALLOW_O, READ_ALLOW_O,
//   DATA_O, DATA_VALID_O, INIT_DONE_O, MEM_* out.
interface trb_mem_arbiter_if
  import dtb_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
  parameter int DATA_WIDTH = TRB_WIDTH
);

  logic                  CLEAR_I;
  logic                  WRITE_I;
  logic [ADDR_WIDTH-1:0] WRITE_PTR_I;
  logic [ADDR_WIDTH-1:0] READ_PTR_I;
  logic [DATA_WIDTH-1:0] DATA_I;
  logic                  RW_TURN_O;
  logic                  WRITE_ALLOW_O;
  logic                  READ_ALLOW_O;
  logic [DATA_WIDTH-1:0] DATA_O;
  logic                  DATA_VALID_O;
  logic                  INIT_DONE_O;
  logic                  MEM_EN_O;
  logic                  MEM_WE_O;
  logic [ADDR_WIDTH-1:0] MEM_ADDR_O;
  logic [DATA_WIDTH-1:0] MEM_WDATA_O;
  logic [DATA_WIDTH-1:0] MEM_RDATA_I;

  modport slave (
    input  CLEAR_I,
    input  WRITE_I,
    input  WRITE_PTR_I,
    input  READ_PTR_I,
    input  DATA_I,
    input  MEM_RDATA_I,
    output RW_TURN_O,
    output WRITE_ALLOW_O,
    output READ_ALLOW_O,
    output DATA_O,
    output DATA_VALID_O,
    output INIT_DONE_O,
    output MEM_EN_O,
    output MEM_WE_O,
    output MEM_ADDR_O,
    output MEM_WDATA_O
  );

  modport master (
    output CLEAR_I,
    output WRITE_I,
    output WRITE_PTR_I,
    output READ_PTR_I,
    output DATA_I,
    output MEM_RDATA_I,
    input  RW_TURN_O,
    input  WRITE_ALLOW_O,
    input  READ_ALLOW_O,
    input  DATA_O,
    input  DATA_VALID_O,
    input  INIT_DONE_O,
    input  MEM_EN_O,
    input  MEM_WE_O,
    input  MEM_ADDR_O,
    input  MEM_WDATA_O
  );

endinterface

// File: rtl/trb_mem_arbiter.sv
// Single-port trace buffer arbiter: zero-fill sweep, then
// read/write slot sequencing, full/empty, read data capture.
// Ports: CLK_I, RST_NI (async, active low), bus (slave).
// Option: TRB_ARB_ADAPTIVE_EN selects demand-driven turns
//   (burst-limited writes) instead of strict alternation.
module trb_mem_arbiter
  import dtb_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
  parameter int DATA_WIDTH = TRB_WIDTH
) (
  input logic         CLK_I,
  input logic         RST_NI,
  trb_mem_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST = '1;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic                  w_run;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr_allow;
  logic                  w_rd_allow;
  logic                  w_turn;
  logic                  w_wr_go;
  logic                  w_rd_go;
  logic [ADDR_WIDTH-1:0] w_wptr_inc;

  assign w_run      = (r_state == RUN);
  assign w_wptr_inc = bus.WRITE_PTR_I + 1'b1;
  assign w_empty    = (bus.READ_PTR_I == bus.WRITE_PTR_I);
  // Wraps naturally: one slot stays unused.
  assign w_full     = (w_wptr_inc == bus.READ_PTR_I);
  assign w_wr_allow = w_run & ~w_full;
  assign w_rd_allow = w_run & ~w_empty;

`ifdef TRB_ARB_ADAPTIVE_EN
  logic [1:0] r_wburst;

  assign w_turn = w_run & bus.WRITE_I & w_wr_allow &
                  (r_wburst < 2'(TRB_ARB_MAX_WBURST));

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_wburst <= '0;
    end else if (bus.CLEAR_I || !w_run || !w_turn) begin
      r_wburst <= '0;
    end else if (r_wburst != 2'd3) begin
      r_wburst <= r_wburst + 2'd1;
    end
  end
`else
  logic r_turn;

  assign w_turn = w_run & r_turn;

  // First RUN cycle is a write slot, then toggle.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_turn <= 1'b0;
    end else if (bus.CLEAR_I) begin
      r_turn <= 1'b0;
    end else if (!w_run) begin
      r_turn <= (r_cnt == LP_LAST);
    end else begin
      r_turn <= ~r_turn;
    end
  end
`endif

  assign w_wr_go = w_turn & bus.WRITE_I & w_wr_allow &
                   ~bus.CLEAR_I;
  assign w_rd_go = w_run & ~w_turn & w_rd_allow &
                   ~bus.CLEAR_I;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.MEM_EN_O    = 1'b0;
    bus.MEM_WE_O    = 1'b0;
    bus.MEM_ADDR_O  = '0;
    bus.MEM_WDATA_O = '0;
    unique case (r_state)
      INIT: begin
        // Held quiet while reset is asserted.
        bus.MEM_EN_O   = RST_NI;
        bus.MEM_WE_O   = RST_NI;
        bus.MEM_ADDR_O = r_cnt;
        if (r_cnt == LP_LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_wr_go) begin
          bus.MEM_EN_O    = 1'b1;
          bus.MEM_WE_O    = 1'b1;
          bus.MEM_ADDR_O  = bus.WRITE_PTR_I;
          bus.MEM_WDATA_O = bus.DATA_I;
        end else if (w_rd_go) begin
          bus.MEM_EN_O   = 1'b1;
          bus.MEM_ADDR_O = bus.READ_PTR_I;
        end
      end
      default: w_state_nxt = INIT;
    endcase
    if (bus.CLEAR_I) begin
      w_state_nxt     = INIT;
      bus.MEM_EN_O    = 1'b0;
      bus.MEM_WE_O    = 1'b0;
      bus.MEM_ADDR_O  = '0;
      bus.MEM_WDATA_O = '0;
    end
  end

  // Sweep counter wraps back to 0 as INIT ends.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_cnt <= '0;
    end else if (bus.CLEAR_I) begin
      r_cnt <= '0;
    end else if (!w_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Read slot n -> RAM data in n+1 -> DATA_O in n+2.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_rd_pend <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_pend <= w_rd_go;
      r_valid   <= r_rd_pend & ~bus.CLEAR_I;
      if (r_rd_pend && !bus.CLEAR_I) begin
        r_data <= bus.MEM_RDATA_I;
      end
    end
  end

  assign bus.RW_TURN_O     = w_turn;
  assign bus.WRITE_ALLOW_O = w_wr_allow;
  assign bus.READ_ALLOW_O  = w_rd_allow;
  assign bus.DATA_O        = r_data;
  assign bus.DATA_VALID_O  = r_valid;
  assign bus.INIT_DONE_O   = w_run;

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Directed bench for trb_mem_arbiter (ADDR_WIDTH=4).
// Honours TRB_ARB_ADAPTIVE_EN for turn expectations.
module tb_trb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  trb_mem_arbiter_if #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) bus ();

  trb_mem_arbiter #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .CLK_I (clk),
    .RST_NI(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];

  always @(posedge clk) begin
    if (bus.MEM_EN_O) begin
      if (bus.MEM_WE_O)
        mem[bus.MEM_ADDR_O] <= bus.MEM_WDATA_O;
      else
        bus.MEM_RDATA_I <= mem[bus.MEM_ADDR_O];
    end
  end

`ifdef TRB_ARB_ADAPTIVE_EN
  localparam logic       EXP_T0  = 1'b0;
  localparam logic [7:0] EXP_PAT = 8'b0111_0111;
`else
  localparam logic       EXP_T0  = 1'b1;
  localparam logic [7:0] EXP_PAT = 8'b0101_0101;
`endif

  function automatic logic [13:0] memv();
    return {bus.MEM_EN_O, bus.MEM_WE_O,
            bus.MEM_ADDR_O, bus.MEM_WDATA_O};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_turn(input logic want);
    for (int k = 0; k < 4; k++) begin
      if (bus.RW_TURN_O === want) return;
      tick();
    end
    chk("turn_wait", 32'(bus.RW_TURN_O), 32'(want));
  endtask

  logic [3:0] tw [4];
  logic [3:0] tr [4];
  logic [1:0] ta [4];
  int         len;

  initial begin
    tw = '{4'd15, 4'd7, 4'd8, 4'd0};
    tr = '{4'd0,  4'd8, 4'd8, 4'd15};
    ta = '{2'b01, 2'b01, 2'b10, 2'b11};

    bus.CLEAR_I     = 1'b0;
    bus.WRITE_I     = 1'b0;
    bus.WRITE_PTR_I = '0;
    bus.READ_PTR_I  = '0;
    bus.DATA_I      = '0;
    tick();
    tick();

    chk("rst_done", 32'(bus.INIT_DONE_O), 0);
    chk("rst_mem", 32'(memv()), 0);
    chk("rst_flags",
        32'({bus.RW_TURN_O, bus.WRITE_ALLOW_O,
             bus.READ_ALLOW_O, bus.DATA_VALID_O}), 0);
    chk("rst_data", 32'(bus.DATA_O), 0);

    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("init%0d", i), 32'(memv()),
          32'({2'b11, 4'(i), 8'h00}));
      if (i == 0)
        chk("init_flags",
            32'({bus.RW_TURN_O, bus.WRITE_ALLOW_O,
                 bus.READ_ALLOW_O, bus.INIT_DONE_O}), 0);
      tick();
    end
    chk("run_done", 32'(bus.INIT_DONE_O), 1);
    chk("run_turn", 32'(bus.RW_TURN_O), 32'(EXP_T0));

    // empty buffer, write at 3
    bus.WRITE_PTR_I = 4'd3;
    bus.READ_PTR_I  = 4'd3;
    bus.WRITE_I     = 1'b1;
    bus.DATA_I      = 8'hA5;
    #1;
    chk("emp_allow",
        32'({bus.WRITE_ALLOW_O, bus.READ_ALLOW_O}), 2);
    chk("emp_wr", 32'(memv()), 32'({2'b11, 4'd3, 8'hA5}));
    tick();
    bus.WRITE_I = 1'b0;
    #1;
    chk("emp_rd_idle", 32'(memv()), 0);

    // store 0x3C at word 5
    bus.WRITE_PTR_I = 4'd5;
    bus.READ_PTR_I  = 4'd5;
    bus.DATA_I      = 8'h3C;
    bus.WRITE_I     = 1'b1;
    #1;
    wait_turn(1'b1);
    chk("wr5", 32'(memv()), 32'({2'b11, 4'd5, 8'h3C}));
    tick();

    // wrap-full: write intent ignored
    bus.WRITE_PTR_I = 4'd15;
    bus.READ_PTR_I  = 4'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("full_we%0d", i), 32'(bus.MEM_WE_O), 0);
      tick();
    end
    bus.WRITE_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.WRITE_PTR_I = tw[i];
      bus.READ_PTR_I  = tr[i];
      #1;
      chk($sformatf("allow%0d", i),
          32'({bus.WRITE_ALLOW_O, bus.READ_ALLOW_O}),
          32'(ta[i]));
    end
    bus.WRITE_PTR_I = 4'd8;
    bus.READ_PTR_I  = 4'd8;
    tick();
    tick();
    tick();

    // read word 5
    wait_turn(1'b0);
    bus.READ_PTR_I = 4'd5;
    #1;
    chk("rd_addr", 32'(memv()), 32'({2'b10, 4'd5, 8'h00}));
    tick();
    bus.READ_PTR_I = 4'd8;
    #1;
    chk("rd_n1_dv", 32'(bus.DATA_VALID_O), 0);
    tick();
    chk("rd_n2", 32'({bus.DATA_VALID_O, bus.DATA_O}),
        32'({1'b1, 8'h3C}));
    tick();
    chk("rd_n3", 32'({bus.DATA_VALID_O, bus.DATA_O}),
        32'({1'b0, 8'h3C}));

    // clear while a read is in flight
    tick();
    wait_turn(1'b0);
    bus.READ_PTR_I = 4'd5;
    #1;
    chk("rd2_addr", 32'(memv()), 32'({2'b10, 4'd5, 8'h00}));
    tick();
    bus.READ_PTR_I = 4'd8;
    bus.CLEAR_I    = 1'b1;
    #1;
    chk("clr_dv0", 32'(bus.DATA_VALID_O), 0);
    tick();
    bus.CLEAR_I = 1'b0;
    #1;
    chk("clr_state",
        32'({bus.INIT_DONE_O, bus.DATA_VALID_O}), 0);
    chk("clr_data", 32'(bus.DATA_O), 32'h3C);
    chk("clr_sw0", 32'(memv()), 32'({2'b11, 4'd0, 8'h00}));
    tick();
    chk("clr_sw1", 32'(memv()), 32'({2'b11, 4'd1, 8'h00}));
    len = 0;
    while (len < 20 && !bus.INIT_DONE_O) begin
      tick();
      len++;
    end
    chk("clr_len", 32'(len), 15);

    // turn schedule, write intent held
    bus.WRITE_I = 1'b1;
    bus.DATA_I  = 8'h11;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("turn%0d", i), 32'(bus.RW_TURN_O),
          32'(EXP_PAT[i]));
      tick();
    end
    bus.WRITE_I = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
